// File: rtl/decoder_sequencer.sv
// decoder_sequencer: runs up to three decode milestones in the fixed order
// M3 -> M2 -> M1 and muxes the active milestone onto the shared SRAM port.
// Optional watchdog: define SEQ_TIMEOUT_EN to abort a milestone that stays
// active for TIMEOUT_CYCLES cycles without signalling done.
//
// Handshake: Start and Mx_done are single-cycle pulses sampled on the rising
// edge of Clock. Start is honoured only when idle or in error. Mx_enable is a
// level held for the whole active phase. Mx_done is honoured only while that
// milestone's enable is high. Done is a one-cycle pulse; Error is sticky until
// the next Start.
module decoder_sequencer #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  input  logic [2:0]  Skip_mask,
  output logic        M3_enable,
  output logic        M2_enable,
  output logic        M1_enable,
  input  logic        M3_done,
  input  logic        M2_done,
  input  logic        M1_done,
  input  logic [17:0] M3_address,
  input  logic [17:0] M2_address,
  input  logic [17:0] M1_address,
  input  logic [15:0] M3_write_data,
  input  logic [15:0] M2_write_data,
  input  logic [15:0] M1_write_data,
  input  logic        M3_we_n,
  input  logic        M2_we_n,
  input  logic        M1_we_n,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [31:0] Cycle_count,
  output logic [2:0]  Dbg_state
);

  typedef enum logic [2:0] {
    S_SEQ_IDLE   = 3'd0,
    S_SEQ_M3     = 3'd1,
    S_SEQ_M2     = 3'd2,
    S_SEQ_M1     = 3'd3,
    S_SEQ_FINISH = 3'd4,
    S_SEQ_ERROR  = 3'd5
  } seq_state_e;

  seq_state_e  state_q, state_d;
  logic [2:0]  mask_q, mask_d;     // bit0=skip M3, bit1=skip M2, bit2=skip M1
  logic [31:0] count_q, count_d;
  logic [2:0]  en_q;               // bit0=M3, bit1=M2, bit2=M1
  logic        timeout_hit;

  // First non-skipped milestone at or after position from_m (3=M3, 2=M2,
  // 1=M1); FINISH when every remaining milestone is skipped.
  function automatic seq_state_e pick_next(input logic [2:0] mask,
                                           input logic [1:0] from_m);
    seq_state_e nxt;
    nxt = S_SEQ_FINISH;
    if (!mask[2] && from_m >= 2'd1) nxt = S_SEQ_M1;
    if (!mask[1] && from_m >= 2'd2) nxt = S_SEQ_M2;
    if (!mask[0] && from_m == 2'd3) nxt = S_SEQ_M3;
    return nxt;
  endfunction

`ifdef SEQ_TIMEOUT_EN
  logic [31:0] wd_q, wd_d;

  assign timeout_hit = (wd_q == TIMEOUT_CYCLES - 32'd1);

  // Watchdog restarts on every milestone entry and counts cycles spent in it.
  always_comb begin
    wd_d = 32'd0;
    if (state_d == state_q &&
        (state_q == S_SEQ_M3 || state_q == S_SEQ_M2 || state_q == S_SEQ_M1))
      wd_d = wd_q + 32'd1;
  end

  // Watchdog register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) wd_q <= 32'd0;
    else         wd_q <= wd_d;
  end

  assign Error = (state_q == S_SEQ_ERROR);
`else
  // No watchdog in this build: milestones may run indefinitely.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
  assign Error          = 1'b0;
`endif

  assign Busy = (state_q == S_SEQ_M3) || (state_q == S_SEQ_M2) ||
                (state_q == S_SEQ_M1) || (state_q == S_SEQ_FINISH);

  // Next-state, mask latch and cycle counter update.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    count_d = count_q;
    if (Busy && count_q != 32'hFFFF_FFFF)
      count_d = count_q + 32'd1;
    case (state_q)
      S_SEQ_IDLE, S_SEQ_ERROR: begin
        if (Start) begin
          mask_d  = Skip_mask;
          // The Start cycle itself is the first elapsed cycle of the run.
          count_d = 32'd1;
          state_d = pick_next(Skip_mask, 2'd3);
        end
      end
      S_SEQ_M3: begin
        if (M3_done)          state_d = pick_next(mask_q, 2'd2);
        else if (timeout_hit) state_d = S_SEQ_ERROR;
      end
      S_SEQ_M2: begin
        if (M2_done)          state_d = pick_next(mask_q, 2'd1);
        else if (timeout_hit) state_d = S_SEQ_ERROR;
      end
      S_SEQ_M1: begin
        if (M1_done)          state_d = S_SEQ_FINISH;
        else if (timeout_hit) state_d = S_SEQ_ERROR;
      end
      S_SEQ_FINISH: state_d = S_SEQ_IDLE;
      default:      state_d = S_SEQ_IDLE;
    endcase
  end

  // State, mask, counter and enable registers; enables decode the next state
  // so they change on the same edge as the state.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_SEQ_IDLE;
      mask_q  <= 3'b000;
      count_q <= 32'd0;
      en_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      en_q    <= {state_d == S_SEQ_M1, state_d == S_SEQ_M2, state_d == S_SEQ_M3};
    end
  end

  // Shared SRAM port follows the active milestone; parked when none active.
  always_comb begin
    SRAM_address    = 18'd0;
    SRAM_write_data = 16'd0;
    SRAM_we_n       = 1'b1;
    case (state_q)
      S_SEQ_M3: begin
        SRAM_address    = M3_address;
        SRAM_write_data = M3_write_data;
        SRAM_we_n       = M3_we_n;
      end
      S_SEQ_M2: begin
        SRAM_address    = M2_address;
        SRAM_write_data = M2_write_data;
        SRAM_we_n       = M2_we_n;
      end
      S_SEQ_M1: begin
        SRAM_address    = M1_address;
        SRAM_write_data = M1_write_data;
        SRAM_we_n       = M1_we_n;
      end
      default: ;
    endcase
  end

  assign M3_enable   = en_q[0];
  assign M2_enable   = en_q[1];
  assign M1_enable   = en_q[2];
  assign Done        = (state_q == S_SEQ_FINISH);
  assign Cycle_count = count_q;
  assign Dbg_state   = state_q;

endmodule

// File: doc/decoder_sequencer.md
DECODER_SEQUENCER -- requirements
Module: decoder_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 32'd1000000: maximum cycles a milestone may stay active before abort (macro-dependent, see Configuration).
REQ-002 Clock  input  1  system clock; all state updates on rising edge.
REQ-003 Resetn  input  1  asynchronous active-low reset.
REQ-004 Start  input  1  one-cycle pulse; begins one decode run.
REQ-005 Skip_mask  input  3  bit0=skip M3, bit1=skip M2, bit2=skip M1; sampled only on an accepted Start.
REQ-006 M3_enable, M2_enable, M1_enable  output  1 each  level enable to each milestone, held for its whole active phase.
REQ-007 M3_done, M2_done, M1_done  input  1 each  one-cycle completion pulse from each milestone.
REQ-008 M3_address, M2_address, M1_address  input  18 each  milestone SRAM address.
REQ-009 M3_write_data, M2_write_data, M1_write_data  input  16 each  milestone SRAM write data.
REQ-010 M3_we_n, M2_we_n, M1_we_n  input  1 each  milestone SRAM write enable, active low.
REQ-011 SRAM_address  output  18  shared SRAM port address.
REQ-012 SRAM_write_data  output  16  shared SRAM port write data.
REQ-013 SRAM_we_n  output  1  shared SRAM port write enable, active low.
REQ-014 Busy  output  1  high from the cycle after an accepted Start until Done or Error.
REQ-015 Done  output  1  one-cycle pulse at the end of a successful run.
REQ-016 Error  output  1  sticky abort flag (macro-dependent).
REQ-017 Cycle_count  output  32  cycles elapsed in the current or last run, saturating at 32'hFFFFFFFF.

Function
REQ-018 FSM states: S_SEQ_IDLE, S_SEQ_M3, S_SEQ_M2, S_SEQ_M1, S_SEQ_FINISH, S_SEQ_ERROR; fixed order M3 -> M2 -> M1.
REQ-019 S_SEQ_IDLE + Start: latch Skip_mask, clear Cycle_count, go to the first non-skipped milestone state, or to S_SEQ_FINISH if all three bits are set.
REQ-020 Start is ignored in every state except S_SEQ_IDLE and S_SEQ_ERROR.
REQ-021 Mx_enable is registered and high exactly while the FSM is in S_SEQ_Mx; at most one enable is high in any cycle.
REQ-022 In S_SEQ_Mx, Mx_done moves the FSM to the next non-skipped milestone state, or to S_SEQ_FINISH if none remains. Enable hand-over takes 1 cycle: Mx_enable low and the next enable high on the same edge.
REQ-023 Done inputs of inactive milestones are ignored.
REQ-024 S_SEQ_FINISH lasts exactly one cycle, asserts Done, then returns to S_SEQ_IDLE.
REQ-025 SRAM port mux is combinational on the registered state: in S_SEQ_Mx it passes Mx_address, Mx_write_data and Mx_we_n unchanged. In all other states it drives SRAM_address=0, SRAM_write_data=0, SRAM_we_n=1.
REQ-026 Cycle_count increments by 1 every cycle while Busy and holds its value in S_SEQ_IDLE and S_SEQ_ERROR.
REQ-027 Latency: an accepted Start drives the first enable high on the next edge. With all milestones skipped, Done is high 1 cycle after Start.

Reset
REQ-028 Resetn low, at any time including mid-run: FSM=S_SEQ_IDLE, all enables 0, Busy=0, Done=0, Error=0, Cycle_count=0, latched mask=0, SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0.
REQ-029 On reset deassertion, no milestone is enabled until a new Start.

Configuration
REQ-030 Macro SEQ_TIMEOUT_EN defined: a per-phase watchdog counter clears on each milestone entry. When it reaches TIMEOUT_CYCLES without that milestone's done, the FSM drops all enables, enters S_SEQ_ERROR and sets Error. S_SEQ_ERROR exits only on Start, which clears Error and begins a new run as in REQ-019.
REQ-031 Macro SEQ_TIMEOUT_EN undefined: no watchdog logic, S_SEQ_ERROR unreachable, Error tied to 0, milestones may run indefinitely.

Verification
REQ-032 Start with Skip_mask=3'b000, done pulses after 10/20/30 cycles in phase -> M3, M2, M1 enables in order with no overlap, then Done one cycle later, Cycle_count=62.
REQ-033 Start with Skip_mask=3'b101 -> only M2_enable asserts; M2_done -> Done next cycle.
REQ-034 Start with Skip_mask=3'b111 -> Done high 1 cycle later, no enable ever high, SRAM_we_n stays 1.
REQ-035 In S_SEQ_M2 with M2_we_n=0, M2_address=18'h25000 and M2_write_data=16'hABCD, plus a spurious M1_done -> SRAM port mirrors M2 exactly and the FSM stays in S_SEQ_M2.
REQ-036 Resetn pulsed low mid-M3 -> all outputs at reset values immediately; a following Start restarts from M3.
REQ-037 SEQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, M2 never done -> Error=1 and M2_enable=0 after 16 cycles in M2; a subsequent Start clears Error and restarts the run.
